// File: rtl/iob_slave_fsm.sv
// ---------------------------------------------------------------------------
// iob_slave_fsm
//
// FCLK-domain I/O-bus request generator. It sits upstream of the FSB block and
// produces the Ready input that FSB uses for I/O-space cycles. Each CPU I/O
// access (BACT & IOCS) is handed to the C8M-side I/O bus master as a
// request/acknowledge handshake:
//   IOREQ high  -> the master starts and raises IOACT (acknowledge)
//   IOACT falls -> the access is finished, and IOReady completes the CPU cycle
// The block also handles timeouts, CPU aborts and, optionally, posted writes.
//
// Optional feature: define IOB_POSTWR_EN to enable posted writes. A posted
// write completes the CPU cycle as soon as the address and data are latched.
// The I/O access then runs in the background. Without the macro, the PWPend
// flag is tied to 0, IOPWCS is ignored, and every write waits like a read.
//
// Parameters
//   TO_CYCLES   : FCLK cycles a request may spend in REQ/ACT before it is
//                 aborted (2..255)
//   SYNC_STAGES : synchroniser depth for IOACT (2 or 3)
//
// Ports
//   FCLK    in  fast bus clock, rising-edge
//   nRESin  in  asynchronous active-low reset
//   BACT    in  CPU bus cycle active (from FSB)
//   IOCS    in  current cycle targets I/O space
//   IOPWCS  in  current I/O address may be posted (used only with IOB_POSTWR_EN)
//   nWE     in  CPU write strobe, 0 = write
//   IOACT   in  I/O master busy, asynchronous to FCLK
//   IOREQ   out request to the I/O master
//   IORW    out latched direction, 1 = read, 0 = write
//   IOL0    out one-cycle pulse that latches the CPU address/data
//   IOReady out Ready for the FSB Ready mux
//   IOBERR  out one-cycle pulse on timeout
// ---------------------------------------------------------------------------
module iob_slave_fsm #(
  parameter int TO_CYCLES   = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic FCLK,
  input  logic nRESin,
  input  logic BACT,
  input  logic IOCS,
  input  logic IOPWCS,
  input  logic nWE,
  input  logic IOACT,
  output logic IOREQ,
  output logic IORW,
  output logic IOL0,
  output logic IOReady,
  output logic IOBERR
);

  // LATCH holds IOL0 for one cycle before the request is raised.
  // TOUT holds IOBERR for one cycle before Ready is given.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_ACT   = 3'd3;
  localparam logic [2:0] ST_TOUT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [7:0] TC_VAL = 8'(TO_CYCLES - 1);

  logic [2:0]             state_reg, state_next;
  logic [7:0]             cnt_reg, cnt_next;
  logic                   iorw_reg, iorw_next;
  // The current access must not assert IOReady when it finishes, because the
  // CPU has gone away (abort) or has already been released (posted write).
  logic                   bg_reg, bg_next;
  logic [SYNC_STAGES-1:0] sync_reg;

  logic ioactr;
  logic start;
  logic tc;
  logic abort;
  logic pw_start;
  logic pwpend;
  logic pwready;
  logic pwpend_set;
  logic pwpend_clr;
  logic pwready_set;

  // IOACT synchroniser. Only the last stage is looked at.
  always_ff @(posedge FCLK or negedge nRESin) begin
    if (!nRESin) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], IOACT};
    end
  end

  assign ioactr = sync_reg[SYNC_STAGES-1];
  assign start  = BACT & IOCS;
  assign tc     = (cnt_reg == TC_VAL);
  assign abort  = bg_reg | ~BACT;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    iorw_next   = iorw_reg;
    bg_next     = bg_reg;
    pwpend_set  = 1'b0;
    pwpend_clr  = 1'b0;
    pwready_set = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A pending posted write or a still-busy master stalls a new access.
        if (start && !pwpend && !ioactr) begin
          state_next = ST_LATCH;
          iorw_next  = nWE;
          bg_next    = pw_start;
          pwpend_set = pw_start;
        end
      end

      ST_LATCH: begin
        state_next  = ST_REQ;
        cnt_next    = 8'd0;
        pwready_set = pwpend & BACT;
        if (!BACT) begin
          bg_next = 1'b1;
        end
      end

      ST_REQ: begin
        cnt_next = cnt_reg + 8'd1;
        if (!BACT) begin
          bg_next = 1'b1;
        end
        if (tc) begin
          state_next = ST_TOUT;
          cnt_next   = 8'd0;
          pwpend_clr = 1'b1;
        end else if (ioactr) begin
          state_next = ST_ACT;
        end
      end

      ST_ACT: begin
        cnt_next = cnt_reg + 8'd1;
        if (!BACT) begin
          bg_next = 1'b1;
        end
        // A completion takes priority over a terminal count in the same cycle.
        if (!ioactr) begin
          state_next = abort ? ST_IDLE : ST_DONE;
          pwpend_clr = 1'b1;
        end else if (tc) begin
          state_next = ST_TOUT;
          cnt_next   = 8'd0;
          pwpend_clr = 1'b1;
        end
      end

      ST_TOUT: begin
        state_next = abort ? ST_IDLE : ST_DONE;
      end

      ST_DONE: begin
        if (!BACT) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge FCLK or negedge nRESin) begin
    if (!nRESin) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      iorw_reg  <= 1'b1;
      bg_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      iorw_reg  <= iorw_next;
      bg_reg    <= bg_next;
    end
  end

`ifdef IOB_POSTWR_EN
  logic pwpend_reg;
  logic pwready_reg;

  assign pw_start = ~nWE & IOPWCS;

  // PWPend covers the whole background access. The early Ready is held only
  // until the CPU drops BACT.
  always_ff @(posedge FCLK or negedge nRESin) begin
    if (!nRESin) begin
      pwpend_reg  <= 1'b0;
      pwready_reg <= 1'b0;
    end else begin
      if (pwpend_set) begin
        pwpend_reg <= 1'b1;
      end else if (pwpend_clr) begin
        pwpend_reg <= 1'b0;
      end

      if (pwready_set) begin
        pwready_reg <= 1'b1;
      end else if (!BACT) begin
        pwready_reg <= 1'b0;
      end
    end
  end

  assign pwpend  = pwpend_reg;
  assign pwready = pwready_reg;
`else
  logic unused_pw;

  assign pw_start  = 1'b0;
  assign pwpend    = 1'b0;
  assign pwready   = 1'b0;
  assign unused_pw = IOPWCS ^ pwpend_set ^ pwpend_clr ^ pwready_set;
`endif

  // Every output is decoded from registers only. This means there is no
  // combinational path from IOACT, and reset clears the outputs without a clock.
  assign IOREQ   = (state_reg == ST_REQ);
  assign IOL0    = (state_reg == ST_LATCH);
  assign IOBERR  = (state_reg == ST_TOUT);
  assign IOReady = (state_reg == ST_DONE) | pwready;
  assign IORW    = iorw_reg;

endmodule

// File: tb/tb_iob_slave_fsm.sv
// ---------------------------------------------------------------------------
// tb_iob_slave_fsm
//
// Directed bench for iob_slave_fsm. It uses two instances:
//   dut    : default parameters, used for the read, write, non-I/O and reset
//            scenarios
//   dut_to : TO_CYCLES=16, with its own BACT, used for the timeout scenario
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, or between edges for the asynchronous reset checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iob_slave_fsm;

  logic FCLK;
  logic nRESin;
  logic BACT;
  logic bact_to;
  logic IOCS;
  logic IOPWCS;
  logic nWE;
  logic IOACT;
  logic IOREQ, IORW, IOL0, IOReady, IOBERR;
  logic to_ioreq, to_iorw, to_iol0, to_ioready, to_ioberr;

  int n_cmp = 0;
  int n_err = 0;

  iob_slave_fsm dut (
    .FCLK    (FCLK),
    .nRESin  (nRESin),
    .BACT    (BACT),
    .IOCS    (IOCS),
    .IOPWCS  (IOPWCS),
    .nWE     (nWE),
    .IOACT   (IOACT),
    .IOREQ   (IOREQ),
    .IORW    (IORW),
    .IOL0    (IOL0),
    .IOReady (IOReady),
    .IOBERR  (IOBERR)
  );

  iob_slave_fsm #(.TO_CYCLES(16), .SYNC_STAGES(2)) dut_to (
    .FCLK    (FCLK),
    .nRESin  (nRESin),
    .BACT    (bact_to),
    .IOCS    (IOCS),
    .IOPWCS  (IOPWCS),
    .nWE     (nWE),
    .IOACT   (IOACT),
    .IOREQ   (to_ioreq),
    .IORW    (to_iorw),
    .IOL0    (to_iol0),
    .IOReady (to_ioready),
    .IOBERR  (to_ioberr)
  );

  initial begin
    FCLK = 1'b0;
    forever #5 FCLK = ~FCLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("check %s = %b", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge FCLK);
    @(negedge FCLK);
  endtask

  // Runs one non-posted access on dut from an idle state and checks every phase.
  // After IOACT changes, 2 edges pass through the synchroniser, and the state
  // reacts on the 3rd edge.
  task automatic run_cycle(input string tag, input logic nwe, input logic pwcs);
    BACT = 1'b1; IOCS = 1'b1; nWE = nwe; IOPWCS = pwcs;
    tick();
    check_eq({tag, " iol0 pulse"}, IOL0, 1'b1);
    check_eq({tag, " ioreq not yet"}, IOREQ, 1'b0);
    tick();
    check_eq({tag, " ioreq up"}, IOREQ, 1'b1);
    check_eq({tag, " iol0 done"}, IOL0, 1'b0);
    check_eq({tag, " iorw"}, IORW, nwe);
    check_eq({tag, " no early ready"}, IOReady, 1'b0);
    repeat (5) tick();
    check_eq({tag, " ioreq held"}, IOREQ, 1'b1);
    IOACT = 1'b1;
    tick(); tick();
    check_eq({tag, " ioreq before sync"}, IOREQ, 1'b1);
    tick();
    check_eq({tag, " ioreq dropped in act"}, IOREQ, 1'b0);
    repeat (20) tick();
    check_eq({tag, " no ready in act"}, IOReady, 1'b0);
    IOACT = 1'b0;
    tick(); tick();
    check_eq({tag, " ready before sync"}, IOReady, 1'b0);
    tick();
    check_eq({tag, " ready after fall"}, IOReady, 1'b1);
    check_eq({tag, " no berr"}, IOBERR, 1'b0);
    tick();
    check_eq({tag, " ready held"}, IOReady, 1'b1);
    BACT = 1'b0; IOCS = 1'b0;
    tick();
    check_eq({tag, " ready released"}, IOReady, 1'b0);
  endtask

  initial begin
    nRESin = 1'b1; BACT = 1'b0; bact_to = 1'b0; IOCS = 1'b0;
    IOPWCS = 1'b0; nWE = 1'b1; IOACT = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #2 nRESin = 1'b0;
    #1;
    check_eq("rst ioreq", IOREQ, 1'b0);
    check_eq("rst iorw", IORW, 1'b1);
    check_eq("rst iol0", IOL0, 1'b0);
    check_eq("rst ioready", IOReady, 1'b0);
    check_eq("rst ioberr", IOBERR, 1'b0);
    repeat (2) @(negedge FCLK);
    nRESin = 1'b1;
    tick();

    // Read
    run_cycle("read", 1'b1, 1'b0);

    // Non-I/O cycle is ignored
    BACT = 1'b1; IOCS = 1'b0; nWE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("nonio ioreq", IOREQ, 1'b0);
      check_eq("nonio iol0", IOL0, 1'b0);
      check_eq("nonio ioready", IOReady, 1'b0);
    end
    BACT = 1'b0;
    tick();

`ifdef IOB_POSTWR_EN
    // Posted write: Ready comes at edge 2, and the access continues in the background
    BACT = 1'b1; IOCS = 1'b1; nWE = 1'b0; IOPWCS = 1'b1;
    tick();
    check_eq("pw iol0", IOL0, 1'b1);
    check_eq("pw no ready yet", IOReady, 1'b0);
    tick();
    check_eq("pw early ready", IOReady, 1'b1);
    check_eq("pw ioreq", IOREQ, 1'b1);
    check_eq("pw iorw", IORW, 1'b0);
    BACT = 1'b0; IOCS = 1'b0;
    tick();
    check_eq("pw ready released", IOReady, 1'b0);
    check_eq("pw ioreq after bact", IOREQ, 1'b1);
    // Second access is a read, and it stalls behind the posted write
    BACT = 1'b1; IOCS = 1'b1; nWE = 1'b1; IOPWCS = 1'b0;
    repeat (3) tick();
    check_eq("pw2 stall iol0", IOL0, 1'b0);
    check_eq("pw2 stall ready", IOReady, 1'b0);
    IOACT = 1'b1;
    repeat (3) tick();
    check_eq("pw bg act", IOREQ, 1'b0);
    IOACT = 1'b0;
    repeat (3) tick();
    check_eq("pw bg idle iol0", IOL0, 1'b0);
    check_eq("pw bg idle ready", IOReady, 1'b0);
    tick();
    check_eq("pw2 iol0", IOL0, 1'b1);
    tick();
    check_eq("pw2 ioreq", IOREQ, 1'b1);
    check_eq("pw2 iorw", IORW, 1'b1);
    IOACT = 1'b1;
    repeat (3) tick();
    check_eq("pw2 act", IOREQ, 1'b0);
    IOACT = 1'b0;
    repeat (3) tick();
    check_eq("pw2 ready", IOReady, 1'b1);
    BACT = 1'b0; IOCS = 1'b0;
    tick();
    check_eq("pw2 ready released", IOReady, 1'b0);
`else
    // Without posted writes, a write waits like a read (IOPWCS is ignored)
    run_cycle("write", 1'b0, 1'b1);
`endif

    // Timeout on dut_to (TO_CYCLES=16) with IOACT held low
    bact_to = 1'b1; IOCS = 1'b1; nWE = 1'b1; IOPWCS = 1'b0; IOACT = 1'b0;
    tick();
    check_eq("to iol0", to_iol0, 1'b1);
    tick();
    check_eq("to ioreq up", to_ioreq, 1'b1);
    repeat (15) tick();
    check_eq("to ioreq cycle16", to_ioreq, 1'b1);
    check_eq("to no berr yet", to_ioberr, 1'b0);
    tick();
    check_eq("to berr pulse", to_ioberr, 1'b1);
    check_eq("to ioreq dropped", to_ioreq, 1'b0);
    check_eq("to ready not yet", to_ioready, 1'b0);
    tick();
    check_eq("to berr single", to_ioberr, 1'b0);
    check_eq("to ready", to_ioready, 1'b1);
    bact_to = 1'b0; IOCS = 1'b0;
    tick();
    check_eq("to ready released", to_ioready, 1'b0);

    // Reset during ACT of a write
    BACT = 1'b1; IOCS = 1'b1; nWE = 1'b0; IOPWCS = 1'b0;
    tick(); tick();
    IOACT = 1'b1;
    repeat (3) tick();
    check_eq("mid iorw write", IORW, 1'b0);
    check_eq("mid in act", IOREQ, 1'b0);
    #2 nRESin = 1'b0;
    #1;
    check_eq("mid rst ioreq", IOREQ, 1'b0);
    check_eq("mid rst ioready", IOReady, 1'b0);
    check_eq("mid rst ioberr", IOBERR, 1'b0);
    check_eq("mid rst iorw", IORW, 1'b1);
    check_eq("mid rst iol0", IOL0, 1'b0);
    @(negedge FCLK);
    IOACT = 1'b0; BACT = 1'b0; IOCS = 1'b0;
    repeat (3) tick();
    nRESin = 1'b1;
    tick();
    run_cycle("post-rst read", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
